// File: rtl/rv32i_stage_buffer.sv
// Packet types shared by the pipeline stages, and an in-order FIFO buffer between two stages.
// The buffer presents a no-op bubble when empty and strips register write-back from packets targeting x0.
package rv32i_pkg;

  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } rv32i_data_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
  } rv32i_inst_t;

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] mem;
    logic       wb;
    logic       load_regfile;
    logic       data_mem_read;
    logic       data_mem_write;
    logic [3:0] data_mem_byte_enable;
  } rv32i_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    rv32i_data_t data;
    rv32i_inst_t inst;
    rv32i_ctrl_t ctrl;
  } rv32i_packet_t;

endpackage

module rv32i_stage_buffer
  import rv32i_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  rv32i_packet_t       in_packet,
  output logic                out_valid,
  input  logic                out_ready,
  output rv32i_packet_t       out_packet,
  output logic [CNT_W-1:0]    count,
  output logic [15:0]         drop_cnt
);

  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam rv32i_packet_t   BUBBLE = '0;

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rv32i_stage_buffer: DEPTH must be a power of two in 2..8");
  end

  function automatic rv32i_packet_t sanitise(input rv32i_packet_t p);
    rv32i_packet_t s;
    s = p;
    if (p.inst.rd == 5'd0) begin
      s.ctrl.load_regfile = 1'b0;
      s.ctrl.wb           = 1'b0;
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [CNT_W:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + 17'(inc);
    if (sum[16]) return 16'hFFFF;
    return sum[15:0];
  endfunction

  rv32i_packet_t        entry_p0 [DEPTH];
  logic [DEPTH-1:0]     vld_p0;
  logic [PTR_W-1:0]     head_p0;
  logic [PTR_W-1:0]     tail_p0;
  logic [CNT_W-1:0]     count_p0;
  logic [15:0]          drop_p0;

  logic                 enq;
  logic                 deq;
  logic [CNT_W:0]       drop_inc;

  // Handshake decode: in_ready depends only on registered occupancy, flush and reset.
  assign in_ready  = rst & (count_p0 < FULL) & ~flush;
  assign out_valid = (count_p0 != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // A packet taken by downstream on the flush edge is not a drop.
  assign drop_inc  = {1'b0, count_p0} - (CNT_W + 1)'(deq) + (CNT_W + 1)'(in_valid);

  // Storage stage: payload is not reset, only the bookkeeping that qualifies it.
  always_ff @(posedge clk) begin
    if (enq) entry_p0[tail_p0] <= sanitise(in_packet);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= '0;
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
      drop_p0  <= '0;
    end else if (flush) begin
      vld_p0   <= '0;
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
      drop_p0  <= sat_add16(drop_p0, drop_inc);
    end else begin
      if (deq) begin
        vld_p0[head_p0] <= 1'b0;
        head_p0         <= head_p0 + PTR_W'(1);
      end
      if (enq) begin
        vld_p0[tail_p0] <= 1'b1;
        tail_p0         <= tail_p0 + PTR_W'(1);
      end
      count_p0 <= count_p0 + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Output stage: head entry straight from storage, bubble whenever empty.
  assign out_packet = out_valid ? entry_p0[head_p0] : BUBBLE;
  assign count      = count_p0;
  assign drop_cnt   = drop_p0;

  a_no_enq_full : assert property (@(posedge clk) disable iff (!rst)
    !(enq && count_p0 == FULL));

  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count_p0 <= FULL);

  a_bubble_noop : assert property (@(posedge clk) disable iff (!rst)
    !out_valid |-> (out_packet.ctrl.ex == '0 && out_packet.ctrl.mem == '0 && !out_packet.ctrl.wb));

  a_head_valid : assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> vld_p0[head_p0]);

endmodule

// File: tb/tb_rv32i_stage_buffer.sv
// Bench for rv32i_stage_buffer: directed vector table, hand-written reset sequences,
// and random traffic checked against a queue-based model.
module tb_rv32i_stage_buffer;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  rv32i_packet_t      in_packet;
  logic               out_valid;
  logic               out_ready;
  rv32i_packet_t      out_packet;
  logic [CNT_W-1:0]   count;
  logic [15:0]        drop_cnt;

  always #5 clk = ~clk;

  rv32i_stage_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  rv32i_packet_t q[$];
  int            mdrop = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        lr;
    logic        wb;
    logic        exp_ir;
    int          exp_cnt;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic        exp_lr;
    logic        exp_wb;
    int          exp_drop;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_pkt(input string name, input rv32i_packet_t act, input rv32i_packet_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic rv32i_packet_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic lr, input logic wb);
    rv32i_packet_t p;
    p = '0;
    p.pc                 = pc;
    p.inst.rd            = rd;
    p.inst.opcode        = 7'h33;
    p.data.rs1_val       = pc ^ 32'hA5A5_0000;
    p.ctrl.ex            = 4'h5;
    p.ctrl.mem           = 2'b01;
    p.ctrl.wb            = wb;
    p.ctrl.load_regfile  = lr;
    p.ctrl.data_mem_read = 1'b1;
    return p;
  endfunction

  function automatic rv32i_packet_t rnd_pkt();
    rv32i_packet_t p;
    p.pc                        = $urandom & 32'hFFFF_FFFC;
    p.data.rs1_val              = $urandom;
    p.data.rs2_val              = $urandom;
    p.data.imm                  = $urandom;
    p.inst.opcode               = 7'($urandom);
    p.inst.rd                   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    p.inst.funct3               = 3'($urandom);
    p.inst.rs1                  = 5'($urandom);
    p.inst.rs2                  = 5'($urandom);
    p.inst.funct7               = 7'($urandom);
    p.ctrl.ex                   = 4'($urandom);
    p.ctrl.mem                  = 2'($urandom);
    p.ctrl.wb                   = 1'($urandom);
    p.ctrl.load_regfile         = 1'($urandom);
    p.ctrl.data_mem_read        = 1'($urandom);
    p.ctrl.data_mem_write       = 1'($urandom);
    p.ctrl.data_mem_byte_enable = 4'($urandom);
    return p;
  endfunction

  // What the buffer should hold for an accepted packet: x0 writes lose their write-back.
  function automatic rv32i_packet_t expect_stored(input rv32i_packet_t p);
    rv32i_packet_t s;
    s = p;
    if (p.inst.rd == 5'd0) begin
      s.ctrl.wb           = 1'b0;
      s.ctrl.load_regfile = 1'b0;
    end
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    rv32i_packet_t exp;
    exp = (q.size() != 0) ? q[0] : rv32i_packet_t'('0);
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk_pkt({tag, ".out_packet"}, out_packet, exp);
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(mdrop));
  endtask

  // One clock of traffic against the model: inputs applied just after an edge, outputs checked just after the next.
  task automatic cycle(input logic fl, input logic iv, input logic ordy,
                       input rv32i_packet_t p, input string tag);
    bit mready, menq, mdeq;
    int d;
    flush = fl; in_valid = iv; out_ready = ordy; in_packet = p;
    #1;
    mready = (q.size() < DEPTH) && !fl;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mready));
    menq = iv && mready;
    mdeq = (q.size() > 0) && ordy;
    if (fl) begin
      d = mdrop + q.size() - (mdeq ? 1 : 0) + (iv ? 1 : 0);
      mdrop = (d > 65535) ? 65535 : d;
      q.delete();
    end else begin
      if (mdeq) void'(q.pop_front());
      if (menq) q.push_back(expect_stored(p));
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic add(input logic fl, input logic iv, input logic ordy, input logic [31:0] pc,
                     input logic [4:0] rd, input logic lr, input logic wb, input logic ir,
                     input int cnt, input logic ov, input logic [31:0] opc,
                     input logic olr, input logic owb, input int drop);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.rd = rd; v.lr = lr; v.wb = wb;
    v.exp_ir = ir; v.exp_cnt = cnt; v.exp_ov = ov; v.exp_pc = opc;
    v.exp_lr = olr; v.exp_wb = owb; v.exp_drop = drop;
    vt.push_back(v);
  endtask

  initial begin
    rv32i_packet_t pend;
    bit            have;
    bit            accepted;
    logic          fl, ordy;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_packet = '0;

    // Reset then idle
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("idle.count",     32'(count),     32'd0);
    chk("idle.out_valid", 32'(out_valid), 32'd0);
    chk("idle.in_ready",  32'(in_ready),  32'd1);
    chk("idle.ctrl",      32'(out_packet.ctrl), 32'd0);
    chk("idle.drop_cnt",  32'(drop_cnt),  32'd0);

    //   fl iv rdy pc       rd lr wb | ir cnt ov out_pc   lr wb drop
    // stream
    add(0, 1, 1, 32'h60,  1, 1, 1,   1, 1, 1, 32'h60,  1, 1, 0);
    add(0, 1, 1, 32'h64,  2, 1, 1,   1, 1, 1, 32'h64,  1, 1, 0);
    add(0, 1, 1, 32'h68,  3, 1, 1,   1, 1, 1, 32'h68,  1, 1, 0);
    add(0, 0, 1, 32'h0,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0, 0);
    // backpressure
    add(0, 1, 0, 32'h100, 4, 1, 0,   1, 1, 1, 32'h100, 1, 0, 0);
    add(0, 1, 0, 32'h104, 4, 1, 0,   1, 2, 1, 32'h100, 1, 0, 0);
    add(0, 1, 0, 32'h108, 4, 1, 0,   0, 2, 1, 32'h100, 1, 0, 0);
    add(0, 1, 1, 32'h108, 4, 1, 0,   0, 1, 1, 32'h104, 1, 0, 0);
    add(0, 1, 1, 32'h108, 4, 1, 0,   1, 1, 1, 32'h108, 1, 0, 0);
    add(0, 0, 1, 32'h0,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0, 0);
    // x0 sanitise
    add(0, 1, 0, 32'h200, 0, 1, 1,   1, 1, 1, 32'h200, 0, 0, 0);
    add(0, 1, 0, 32'h204, 5, 1, 1,   1, 2, 1, 32'h200, 0, 0, 0);
    add(0, 0, 1, 32'h0,   0, 0, 0,   0, 1, 1, 32'h204, 1, 1, 0);
    add(0, 1, 0, 32'h208, 6, 1, 1,   1, 2, 1, 32'h204, 1, 1, 0);
    // flush with two stored and one incoming
    add(1, 1, 0, 32'h20C, 7, 1, 1,   0, 0, 0, 32'h0,   0, 0, 3);
    add(0, 0, 0, 32'h0,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0, 3);
    // flush coinciding with a dequeue
    add(0, 1, 0, 32'h300, 1, 1, 1,   1, 1, 1, 32'h300, 1, 1, 3);
    add(0, 1, 0, 32'h304, 1, 1, 1,   1, 2, 1, 32'h300, 1, 1, 3);
    add(1, 0, 1, 32'h0,   0, 0, 0,   0, 0, 0, 32'h0,   0, 0, 4);

    foreach (vt[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      flush = vt[i].fl; in_valid = vt[i].iv; out_ready = vt[i].ordy;
      in_packet = mk(vt[i].pc, vt[i].rd, vt[i].lr, vt[i].wb);
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(vt[i].exp_ir));
      @(posedge clk); #1;
      chk({tag, ".count"},     32'(count),     32'(vt[i].exp_cnt));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(vt[i].exp_ov));
      chk({tag, ".pc"},        out_packet.pc,  vt[i].exp_pc);
      chk({tag, ".lr"},        32'(out_packet.ctrl.load_regfile), 32'(vt[i].exp_lr));
      chk({tag, ".wb"},        32'(out_packet.ctrl.wb), 32'(vt[i].exp_wb));
      chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(vt[i].exp_drop));
    end

    // The table leaves the buffer empty after a flush; hand over to the model.
    q.delete();
    mdrop = vt[vt.size() - 1].exp_drop;

    have = 1'b0;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      fl   = ($urandom_range(0, 15) == 0);
      ordy = 1'($urandom_range(0, 1));
      if (!have && $urandom_range(0, 3) != 0) begin
        pend = rnd_pkt();
        have = 1'b1;
      end
      accepted = have && !fl && (q.size() < DEPTH);
      cycle(fl, have, ordy, have ? pend : rv32i_packet_t'('0), "rnd");
      if (fl || accepted) have = 1'b0;
    end

    // Async reset mid-stream with two entries held
    cycle(1'b1, 1'b1, 1'b0, rnd_pkt(), "pre6.flush");
    cycle(1'b0, 1'b1, 1'b0, rnd_pkt(), "pre6.push0");
    cycle(1'b0, 1'b1, 1'b0, rnd_pkt(), "pre6.push1");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.count",     32'(count),     32'd0);
    chk("arst.drop_cnt",  32'(drop_cnt),  32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd0);
    chk_pkt("arst.out_packet", out_packet, rv32i_packet_t'('0));
    q.delete();
    mdrop = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, rnd_pkt(), "post6.push");
    cycle(1'b0, 1'b0, 1'b1, rv32i_packet_t'('0), "post6.pop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
